// File: rtl/mnist_pixel_loader.sv
// mnist_pixel_loader
// Binarizes an 8-bit grayscale pixel stream, packs 8 pixels per byte (first
// pixel in bit 7) and strobes each byte into the classifier's shift-in port.
// After the last byte of a frame it waits SETTLE_CYCLES for the classifier
// to resolve, then pulses frame_done.
module mnist_pixel_loader #(
    parameter int PIXELS        = 784,
    parameter int THRESHOLD     = 128,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic [7:0] pixels_out,
    output logic       write_enable,
    output logic       busy,
    output logic [6:0] byte_count,
    output logic       frame_done
);

    localparam int             BYTES = PIXELS / 8;
    localparam int             SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0]     THR   = 8'(THRESHOLD);
    localparam logic [6:0]     LAST_BYTE_IDX = 7'(BYTES - 1);
    localparam logic [SW-1:0]  SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [7:0]    r_pack;
    logic [2:0]    r_bit_cnt;
    logic [6:0]    r_byte_cnt;
    logic [SW-1:0] r_settle_cnt;
    logic [7:0]    r_pixels_out;
    logic          r_write_enable;

    logic          w_start_ok;
    logic          w_hs;
    logic          w_pix_bit;
    logic [7:0]    w_packed;
    logic          w_byte_done;
    logic          w_last_byte;
    logic          w_settle_end;

    // Accepting a start needs abort low; abort always wins.
    assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
    // pix_ready is simply "in LOAD", so a handshake is LOAD with pix_valid.
    assign w_hs         = (r_state == S_LOAD) && pix_valid;
    assign w_pix_bit    = (pix_data >= THR);
    assign w_packed     = {r_pack[6:0], w_pix_bit};
    assign w_byte_done  = w_hs && (r_bit_cnt == 3'd7);
    assign w_last_byte  = w_byte_done && (r_byte_cnt == LAST_BYTE_IDX);
    assign w_settle_end = (r_settle_cnt == SETTLE_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always assigned with <=, so every register
        // samples pre-edge values and the order of statements does not matter.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort in any non-IDLE state returns to IDLE.
    always_comb begin
        // NOTE: default first so every path assigns w_next_state and no latch
        // is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next_state = S_LOAD;
            end
            S_LOAD: begin
                if (abort)            w_next_state = S_IDLE;
                else if (w_last_byte) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)             w_next_state = S_IDLE;
                else if (w_settle_end) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Pixel packing, byte strobe and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack         <= 8'd0;
            r_bit_cnt      <= 3'd0;
            r_byte_cnt     <= 7'd0;
            r_pixels_out   <= 8'd0;
            r_write_enable <= 1'b0;
        end else begin
            r_write_enable <= 1'b0;
            if (w_start_ok) begin
                r_pack     <= 8'd0;
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 7'd0;
            end else if (abort) begin
                // Partial byte (and any byte completing on this edge) is dropped.
                r_pack    <= 8'd0;
                r_bit_cnt <= 3'd0;
            end else if (w_hs) begin
                r_pack    <= w_packed;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    r_pixels_out   <= w_packed;
                    r_write_enable <= 1'b1;
                    r_byte_cnt     <= r_byte_cnt + 7'd1;
                end
            end
        end
    end

    // Settle counter: runs only while in SETTLE, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
        end else if (r_state == S_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    assign pix_ready    = (r_state == S_LOAD);
    assign busy         = (r_state != S_IDLE);
    assign frame_done   = (r_state == S_DONE);
    assign pixels_out   = r_pixels_out;
    assign write_enable = r_write_enable;
    assign byte_count   = r_byte_cnt;

endmodule

// File: doc/mnist_pixel_loader.md
Name: mnist_pixel_loader

Overview:
Upstream feeder for the MNIST logic-gate classifier top level. Accepts an 8-bit grayscale pixel stream over a valid/ready handshake and binarizes each pixel against a threshold. Packs 8 binary pixels per byte and drives the classifier's byte-wide shift-in port (pixels_out / write_enable). Once a full frame is loaded it waits a settle interval for the combinational net and popcount to resolve, then pulses frame_done.

Parameters:
PIXELS, 784, pixels per frame; must be a multiple of 8
THRESHOLD, 128, 8-bit binarization threshold; bit = (pix_data >= THRESHOLD)
SETTLE_CYCLES, 4, idle cycles after the last write_enable before frame_done; minimum 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin loading a new frame (sampled in IDLE only)
abort  input  1  synchronous cancel of the frame in progress
pix_valid  input  1  upstream pixel valid
pix_data  input  8  grayscale pixel, 0..255
pix_ready  output  1  loader can accept a pixel
pixels_out  output  8  packed byte to classifier pixels_in
write_enable  output  1  one-cycle strobe; classifier shifts pixels_out in
busy  output  1  high in any state other than IDLE
byte_count  output  7  bytes written this frame, 0..PIXELS/8
frame_done  output  1  one-cycle pulse: classifier outputs valid for this frame

Behaviour:
- Reset is asynchronous and active-low on rst_n, single clock clk. Reset values are all outputs 0 and state IDLE. Internal pack register, bit counter and settle counter are 0.
- FSM states: IDLE, LOAD, SETTLE, DONE.
- IDLE: pix_ready=0. If start=1 and abort=0, go to LOAD and clear byte_count, bit counter and pack register. start and abort together: abort wins, stay IDLE.
- LOAD: pix_ready=1. A handshake occurs on a rising edge with pix_valid & pix_ready.
  - Each handshake shifts the binarized bit into the pack register LSB, so the first pixel of a group lands in bit 7.
  - On the 8th handshake of a group, pixels_out is registered with the full byte, write_enable is high for exactly the next cycle, byte_count increments, and the bit counter wraps to 0.
  - Resulting frame order: the first frame pixel ends at the classifier's input MSB (x[783]).
  - start is ignored in LOAD.
- On the handshake that completes byte PIXELS/8, the next state is SETTLE and pix_ready drops the following cycle. No further pixels are accepted even if pix_valid stays high.
- SETTLE: pix_ready=0. Counts SETTLE_CYCLES cycles, then moves to DONE.
- DONE: frame_done=1 for one cycle, then IDLE. byte_count holds PIXELS/8 until the next start.
- Timing: final handshake on edge n gives write_enable high in cycle n+1 and frame_done high in cycle n+1+SETTLE_CYCLES.
- pixels_out holds its last value while write_enable=0. write_enable is never high in IDLE, SETTLE or DONE, except the final-byte strobe in the first SETTLE cycle.
- abort=1 in LOAD, SETTLE or DONE: next cycle is IDLE and the partial byte is discarded.
  - A byte completed on the same edge as abort is also discarded: no write_enable, no frame_done.
  - byte_count keeps the count reached before abort.
- pix_valid gaps of any length are allowed in LOAD; state and counters hold.
- Comparison is unsigned: 127 gives 0, 128 gives 1, 255 gives 1, 0 gives 0.
- Reset mid-frame returns immediately to IDLE with all outputs 0.

Test Plan:
1. Full frame, pix_valid always 1, pixels alternating 200,10 → 98 write_enable strobes one cycle apart every 8 accepts; every pixels_out=8'hAA; byte_count=98; frame_done exactly 5 cycles after the last handshake.
2. Threshold edges: pixels 127,128,0,255,129,126,128,127 → first pixels_out=8'b01011010.
3. Random pix_valid gaps (30% duty) with a ramp 0..255 repeating → output bytes match the reference packing; write_enable count=98; pix_ready low after the last accept despite pix_valid=1.
4. abort after 13 pixels (byte 1 written) → byte_count=1, no further write_enable, no frame_done; a new start then gives a fresh 98-byte frame with correct packing.
5. start and abort asserted together in IDLE → stays IDLE, busy=0. start pulsed during LOAD → no effect on counters.
6. rst_n low asynchronously mid-SETTLE → outputs 0 immediately, no frame_done; after release, state is IDLE and pix_ready=0.
